// File: rtl/s_perm_checker.sv
// s_perm_checker
//   Streams all 256 bytes of the S RAM through its read port and reports
//   whether the contents are a permutation of 0..255 and whether they are
//   the identity, along with duplicate diagnostics.
//
// Handshake: rdy=1 means the block is idle and its results are stable. A start
//   is accepted on any clock edge where rdy=1 and en=1. rdy then drops for the
//   whole run. It rises again, with final results, 257+READ_LAT cycles after
//   the accept edge. en seen while rdy=0 is ignored and is not queued.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   rdy, en        idle indication / start request
//   ram_addr       S RAM read address (0..255, one per cycle while issuing)
//   ram_dout       S RAM read data, READ_LAT cycles after ram_addr
//   ram_din        tied to 0
//   ram_wren       tied to 0; this block only reads
//   is_perm        every value 0..255 seen exactly once
//   is_ident       S[i]==i for all i
//   dup_count      number of reads whose value had already been seen
//   first_dup_addr address of the first duplicate read (0 if none)
//   dbg_state      current FSM state (IDLE/ISSUE/DRAIN/DONE)
module s_perm_checker #(
  parameter int READ_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       rdy,
  input  logic       en,
  output logic [7:0] ram_addr,
  input  logic [7:0] ram_dout,
  output logic [7:0] ram_din,
  output logic       ram_wren,
  output logic       is_perm,
  output logic       is_ident,
  output logic [8:0] dup_count,
  output logic [7:0] first_dup_addr,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] DRAIN_LAST = 2'(READ_LAT - 1);

  state_t       state;
  state_t       state_nx;
  logic [8:0]   issue_cnt;
  logic [1:0]   drain_cnt;
  logic [255:0] seen;

  // (valid, addr) tags that travel alongside the RAM read pipeline. The last
  // stage lines up with ram_dout.
  logic [READ_LAT-1:0] pipe_vld;
  logic [7:0]          pipe_addr [READ_LAT];

  logic       accept;
  logic       smp_vld;
  logic [7:0] smp_addr;
  logic       smp_dup;

  assign accept    = rdy & en;
  assign smp_vld   = pipe_vld[READ_LAT-1];
  assign smp_addr  = pipe_addr[READ_LAT-1];
  assign smp_dup   = seen[ram_dout];
  assign ram_din   = 8'd0;
  assign ram_wren  = 1'b0;
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = ISSUE;
      // issue_cnt reaches 256 on the same edge that leaves ISSUE.
      ISSUE:   if (issue_cnt == 9'd255) state_nx = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rdy            <= 1'b0;
      issue_cnt      <= 9'd0;
      drain_cnt      <= 2'd0;
      ram_addr       <= 8'd0;
      seen           <= '0;
      pipe_vld       <= '0;
      is_perm        <= 1'b0;
      is_ident       <= 1'b0;
      dup_count      <= 9'd0;
      first_dup_addr <= 8'd0;
      for (int i = 0; i < READ_LAT; i++) pipe_addr[i] <= 8'd0;
    end else begin
      state <= state_nx;
      // rdy is registered so that it stays low while rst is high and rises on
      // the first edge after rst is released.
      rdy   <= (state_nx == IDLE);

      pipe_vld[0]  <= (state == ISSUE);
      pipe_addr[0] <= ram_addr;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end

      if (accept) begin
        issue_cnt      <= 9'd0;
        drain_cnt      <= 2'd0;
        ram_addr       <= 8'd0;
        seen           <= '0;
        is_perm        <= 1'b1;
        is_ident       <= 1'b1;
        dup_count      <= 9'd0;
        first_dup_addr <= 8'd0;
      end else begin
        if (state == ISSUE) begin
          issue_cnt <= issue_cnt + 9'd1;
          // Hold at 255 after the last issue instead of wrapping to 0.
          if (ram_addr != 8'hFF) ram_addr <= ram_addr + 8'd1;
        end
        if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
        // The pipeline is empty in IDLE, so no sample can coincide with an
        // accept.
        if (smp_vld) begin
          seen[ram_dout] <= 1'b1;
          if (smp_dup) begin
            dup_count <= dup_count + 9'd1;
            if (dup_count == 9'd0) first_dup_addr <= smp_addr;
            is_perm <= 1'b0;
          end
          if (ram_dout != smp_addr) is_ident <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_s_perm_checker.sv
// Bench for s_perm_checker. Two instances (READ_LAT=1 and READ_LAT=2) share one
// RAM image. Each instance has its own synchronous-read RAM model. Expected
// verdicts come from a counting model over the RAM image.
module tb_s_perm_checker;

  logic clk;
  logic rst;
  logic en1, en2;

  logic       rdy1, rdy2, wren1, wren2, perm1, perm2, ident1, ident2;
  logic [7:0] addr1, addr2, din1, din2, dout1, dout2, fda1, fda2;
  logic [8:0] dup1, dup2;
  logic [1:0] dbg1, dbg2;

  logic [7:0] mem [256];
  logic [7:0] rd1, rd2a, rd2b;

  int tests = 0;
  int fails = 0;
  int sel   = 1;

  // Model outputs
  logic       exp_perm, exp_ident;
  logic [8:0] exp_dup;
  logic [7:0] exp_fda;

  // Observed signals of the instance currently selected
  logic       o_rdy, o_wren, o_perm, o_ident;
  logic [7:0] o_addr, o_din, o_fda;
  logic [8:0] o_dup;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd1  <= mem[addr1];
    rd2a <= mem[addr2];
    rd2b <= rd2a;
  end
  assign dout1 = rd1;
  assign dout2 = rd2b;

  s_perm_checker #(.READ_LAT(1)) u1 (
    .clk(clk), .rst(rst), .rdy(rdy1), .en(en1), .ram_addr(addr1),
    .ram_dout(dout1), .ram_din(din1), .ram_wren(wren1), .is_perm(perm1),
    .is_ident(ident1), .dup_count(dup1), .first_dup_addr(fda1),
    .dbg_state(dbg1)
  );

  s_perm_checker #(.READ_LAT(2)) u2 (
    .clk(clk), .rst(rst), .rdy(rdy2), .en(en2), .ram_addr(addr2),
    .ram_dout(dout2), .ram_din(din2), .ram_wren(wren2), .is_perm(perm2),
    .is_ident(ident2), .dup_count(dup2), .first_dup_addr(fda2),
    .dbg_state(dbg2)
  );

  always_comb begin
    o_rdy = rdy1; o_wren = wren1; o_perm = perm1; o_ident = ident1;
    o_addr = addr1; o_din = din1; o_fda = fda1; o_dup = dup1;
    if (sel == 2) begin
      o_rdy = rdy2; o_wren = wren2; o_perm = perm2; o_ident = ident2;
      o_addr = addr2; o_din = din2; o_fda = fda2; o_dup = dup2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Verdict computed from value occurrence counts in the RAM image.
  task automatic build_model();
    int cnt [256];
    int first;
    int distinct;
    bit ident;
    for (int v = 0; v < 256; v++) cnt[v] = 0;
    first = -1;
    ident = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (cnt[mem[i]] > 0 && first < 0) first = i;
      cnt[mem[i]]++;
      if (int'(mem[i]) != i) ident = 1'b0;
    end
    distinct = 0;
    for (int v = 0; v < 256; v++) if (cnt[v] > 0) distinct++;
    exp_perm  = (distinct == 256);
    exp_ident = ident;
    exp_dup   = 9'(256 - distinct);
    exp_fda   = (first < 0) ? 8'd0 : 8'(first);
  endtask

  // kind: 0 identity, 1 reversed, 2 zeros, 3 random permutation, 4 random bytes
  task automatic fill(input int kind);
    logic [7:0] t;
    int j;
    for (int i = 0; i < 256; i++) begin
      case (kind)
        1:       mem[i] = 8'(255 - i);
        2:       mem[i] = 8'd0;
        4:       mem[i] = 8'($urandom_range(255, 0));
        default: mem[i] = 8'(i);
      endcase
    end
    if (kind == 3) begin
      for (int i = 255; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = mem[i]; mem[i] = mem[j]; mem[j] = t;
      end
    end
  endtask

  // Call at a sample point where the selected instance shows rdy=1. Returns at
  // the first sample point where rdy is back high. With hold=1, en is left
  // asserted so that the next run is accepted back-to-back.
  task automatic do_run(input int w, input bit hold, input string tag);
    int n_low;
    int addr_err;
    bit wr_seen;
    sel = w;
    build_model();
    if (w == 1) en1 = 1'b1; else en2 = 1'b1;
    tick();
    if (!hold) begin
      if (w == 1) en1 = 1'b0; else en2 = 1'b0;
    end
    check({tag, "_cleared"}, {4'd0, o_rdy, o_addr, o_perm, o_ident, o_dup, o_fda},
          {4'd0, 1'b0, 8'd0, 1'b1, 1'b1, 9'd0, 8'd0});
    n_low = 0;
    addr_err = 0;
    wr_seen = 1'b0;
    while (o_rdy == 1'b0 && n_low < 600) begin
      if (n_low < 256 && int'(o_addr) != n_low) addr_err++;
      if (o_wren !== 1'b0 || o_din !== 8'd0) wr_seen = 1'b1;
      n_low++;
      tick();
    end
    check({tag, "_latency"},  n_low, 257 + w);
    check({tag, "_addr_seq"}, addr_err, 0);
    check({tag, "_no_write"}, {31'd0, wr_seen}, 0);
    check({tag, "_is_perm"},  {31'd0, o_perm},  {31'd0, exp_perm});
    check({tag, "_is_ident"}, {31'd0, o_ident}, {31'd0, exp_ident});
    check({tag, "_dup"},      {23'd0, o_dup},   {23'd0, exp_dup});
    check({tag, "_fda"},      {24'd0, o_fda},   {24'd0, exp_fda});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_u1"}, {6'd0, rdy1, addr1, perm1, ident1, dup1, fda1, din1, wren1}, 0);
    check({tag, "_u2"}, {6'd0, rdy2, addr2, perm2, ident2, dup2, fda2, din2, wren2}, 0);
  endtask

  initial begin
    rst = 1'b1;
    en1 = 1'b0;
    en2 = 1'b0;
    fill(0);
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check("rdy_after_reset", {30'd0, rdy1, rdy2}, 32'd3);

    // Directed patterns
    fill(0);
    do_run(1, 1'b0, "ident_l1");
    fill(1);
    do_run(1, 1'b0, "reverse_l1");
    fill(2);
    do_run(1, 1'b0, "zeros_l1");
    fill(0);
    mem[20] = 8'd10;
    do_run(1, 1'b0, "dup20_l1");
    do_run(2, 1'b0, "dup20_l2");

    // Reset in the middle of a run (zeros RAM, so seen bits get set)
    fill(2);
    sel = 1;
    en1 = 1'b1;
    tick();
    en1 = 1'b0;
    repeat (99) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("midrun_rst_a");
    tick();
    check_reset_outputs("midrun_rst_b");
    rst = 1'b0;
    tick();
    check("rdy_after_midrun_rst", {30'd0, rdy1, rdy2}, 32'd3);
    check("results_after_midrun_rst", {14'd0, perm1, ident1, dup1, fda1}, 0);
    fill(0);
    do_run(1, 1'b0, "post_rst_ident");

    // en held high across three back-to-back runs
    fill(0);
    do_run(1, 1'b1, "hold_ident_a");
    fill(2);
    do_run(1, 1'b1, "hold_zeros");
    fill(0);
    do_run(1, 1'b0, "hold_ident_b");

    // Randomized RAM images on both latencies
    for (int k = 0; k < 3; k++) begin
      fill(3);
      do_run(1 + (k % 2), 1'b0, "rand_perm");
      fill(3);
      mem[$urandom_range(255, 1)] = mem[$urandom_range(255, 0)];
      do_run(2 - (k % 2), 1'b0, "rand_perm_dup");
      fill(4);
      do_run(1 + (k % 2), 1'b0, "rand_bytes");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
